// File: rtl/alu_ctrl_pkg.sv
// Shared types and widths for the ALU issue controller and its arbiter.
// Operands are 5-bit signed, opcodes 3-bit, and results 9-bit signed.
package alu_ctrl_pkg;
    localparam int DW  = 5;
    localparam int OPW = 3;
    localparam int RW  = 9;

    // Opcode bit 2 selects the operation class.
    localparam logic OP_ARTH  = 1'b0;
    localparam logic OP_LOGIC = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } alu_ctrl_state_e;
endpackage

// File: rtl/alu_issue_ctrl_rr_arbiter.sv
// Combinational N-way round-robin arbiter. The search starts at ptr and moves
// upward with wrap. Outputs are a one-hot grant and its binary index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);
    // pos[k] is the requester visited k steps after ptr.
    logic [IW:0] pos [N];
    logic        found;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pos
            logic [IW:0] sum;
            assign sum     = {1'b0, ptr} + (IW+1)'(gi);
            assign pos[gi] = (sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum;
        end
    endgenerate

    always_comb begin
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[pos[k][IW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = pos[k][IW-1:0];
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
        gnt_any = found;
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Round-robin issue controller for the shared registered ALU. It accepts one
// operation, runs it through the ALU and returns the tagged result, then repeats.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DW-1:0]     req_in1,
    input  logic [N_REQ*DW-1:0]     req_in2,
    input  logic [N_REQ*OPW-1:0]    req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic signed [RW-1:0]    rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic signed [DW-1:0]    alu_in1,
    output logic signed [DW-1:0]    alu_in2,
    output logic [OPW-1:0]          alu_opcode,
    input  logic signed [RW-1:0]    alu_out,
    output logic [15:0]             issue_cnt
);
    alu_ctrl_state_e state_reg;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  ptr_next;
    logic [IDW-1:0]  gnt_reg;
    logic [DW-1:0]   alu_in1_reg;
    logic [DW-1:0]   alu_in2_reg;
    logic [OPW-1:0]  alu_op_reg;
    logic [RW-1:0]   rsp_data_reg;
    logic            rsp_valid_reg;
    logic [15:0]     issue_cnt_reg;

    logic [N_REQ-1:0] gnt_onehot;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;

    logic [DW-1:0]  in1_arr [N_REQ];
    logic [DW-1:0]  in2_arr [N_REQ];
    logic [OPW-1:0] op_arr  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign in1_arr[gi] = req_in1[gi*DW +: DW];
            assign in2_arr[gi] = req_in2[gi*DW +: DW];
            assign op_arr[gi]  = req_op[gi*OPW +: OPW];
        end
    endgenerate

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_reg),
        .gnt     (gnt_onehot),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // The grant is only offered while idle, so it acts as the accept strobe.
    assign req_ready = (state_reg == IDLE) ? gnt_onehot : '0;
    assign ptr_next  = (gnt_reg == IDW'(N_REQ - 1)) ? '0 : gnt_reg + IDW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            gnt_reg       <= '0;
            alu_in1_reg   <= '0;
            alu_in2_reg   <= '0;
            alu_op_reg    <= '0;
            rsp_data_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            issue_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt_any) begin
                        alu_in1_reg <= in1_arr[gnt_idx];
                        alu_in2_reg <= in2_arr[gnt_idx];
                        alu_op_reg  <= op_arr[gnt_idx];
                        gnt_reg     <= gnt_idx;
                        state_reg   <= EXEC;
                    end
                end
                EXEC: state_reg <= CAPT;
                CAPT: begin
                    rsp_data_reg  <= alu_out;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        issue_cnt_reg <= issue_cnt_reg + 16'd1;
                        ptr_reg       <= ptr_next;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign alu_in1    = alu_in1_reg;
    assign alu_in2    = alu_in2_reg;
    assign alu_opcode = alu_op_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = gnt_reg;
    assign issue_cnt  = issue_cnt_reg;
endmodule
